pl_mem_wb: RTL and testbench

Combined memory-access / write-back stage of the 8-bit RISC-RNS pipeline, directly downstream of the EX stage. Consumes the EX pipeline register (control flags, destination address, per-domain result, data addresses, I/O port ID), runs data-memory load/store transactions over a req/ack handshake, and drives I/O port strobes. Produces the register-file write-back port (integer or RNS file) and the saved carry flag. Stalls upstream stages while a memory transaction is outstanding.

---
 rtl/pl_mem_wb.sv | 228 ++++++++++++++++++++++
 tb/tb_pl_mem_wb.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_mem_wb.sv
// pl_mem_wb: combined memory-access / write-back stage of the 8-bit RISC-RNS pipeline.
// Optional build macro PL_MEM_WB_TIMEOUT_EN aborts unacknowledged memory transactions.
module pl_mem_wb #(
  parameter int unsigned NUM_DOMAINS = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [0:9]               EX_reg,
  input  logic [3:0]               destination_reg_addr,
  input  logic [NUM_DOMAINS*8-1:0] operation_result,
  input  logic [15:0]              data_wr_addr,
  input  logic [15:0]              data_rd_addr,
  input  logic [7:0]               IO_port_ID,
  input  logic [0:4]               branch_conds_EX,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [15:0]              mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata,
  input  logic                     mem_ack,
  output logic [7:0]               io_port_id,
  output logic                     io_rd_strobe,
  output logic                     io_wr_strobe,
  output logic [7:0]               io_out_data,
  input  logic [7:0]               io_in_data,
  output logic                     wb_en,
  output logic [3:0]               wb_addr,
  output logic [NUM_DOMAINS*8-1:0] wb_data,
  output logic                     carry_flag,
  output logic                     stall,
  output logic                     mem_err
);

  localparam int unsigned DW = NUM_DOMAINS * 8;

  localparam int unsigned ExStore   = 0;
  localparam int unsigned ExRegWr   = 1;
  localparam int unsigned ExSaveC   = 2;
  localparam int unsigned ExInval   = 3;
  localparam int unsigned ExLoad    = 4;
  localparam int unsigned ExOutp    = 8;
  localparam int unsigned ExInp     = 9;

  typedef enum logic [1:0] {StIdle, StMemWait, StLdWb} state_e;

  state_e          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [15:0]     mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic [7:0]      io_port_id_q, io_port_id_d;
  logic            io_rd_strb_q, io_rd_strb_d;
  logic            io_wr_strb_q, io_wr_strb_d;
  logic [7:0]      io_out_data_q, io_out_data_d;
  logic            wb_en_q, wb_en_d;
  logic [3:0]      wb_addr_q, wb_addr_d;
  logic [DW-1:0]   wb_data_q, wb_data_d;
  logic            carry_q, carry_d;
  logic [3:0]      ld_dest_q, ld_dest_d;
  logic [3:0]      in_dest_q, in_dest_d;
  logic            instr_valid;

`ifdef PL_MEM_WB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            mem_err_q, mem_err_d;
`else
  logic unused_tmo;
  assign unused_tmo = (MEM_TIMEOUT == 0);
`endif

  logic unused_inputs;
  assign unused_inputs = ^{EX_reg[5:7], branch_conds_EX[0:2], branch_conds_EX[4]};

  // The EX register is frozen (and ignored) while a memory transaction is outstanding.
  assign instr_valid = !EX_reg[ExInval] && (state_q != StMemWait);

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    io_port_id_d  = io_port_id_q;
    io_rd_strb_d  = 1'b0;
    io_wr_strb_d  = 1'b0;
    io_out_data_d = io_out_data_q;
    wb_en_d       = 1'b0;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    carry_d       = carry_q;
    ld_dest_d     = ld_dest_q;
    in_dest_d     = in_dest_q;
`ifdef PL_MEM_WB_TIMEOUT_EN
    tmo_cnt_d     = '0;
    mem_err_d     = mem_err_q;
`endif

    unique case (state_q)
      StIdle, StLdWb: begin
        state_d = StIdle;
        if (instr_valid) begin
          if (EX_reg[ExSaveC]) carry_d = branch_conds_EX[3];
          if (EX_reg[ExStore]) begin
            state_d     = StMemWait;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = data_wr_addr;
            mem_wdata_d = operation_result[7:0];
          end else if (EX_reg[ExLoad]) begin
            state_d    = StMemWait;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = data_rd_addr;
            ld_dest_d  = destination_reg_addr;
          end else if (EX_reg[ExOutp]) begin
            io_wr_strb_d  = 1'b1;
            io_port_id_d  = IO_port_ID;
            io_out_data_d = operation_result[7:0];
          end else if (EX_reg[ExInp]) begin
            io_rd_strb_d = 1'b1;
            io_port_id_d = IO_port_ID;
            in_dest_d    = destination_reg_addr;
          end else if (EX_reg[ExRegWr]) begin
            wb_en_d   = 1'b1;
            wb_addr_d = destination_reg_addr;
            wb_data_d = operation_result;
          end
        end
      end
      StMemWait: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StLdWb;
            wb_en_d   = 1'b1;
            wb_addr_d = ld_dest_q;
            wb_data_d = {{(DW-8){1'b0}}, mem_rdata};
          end
        end
`ifdef PL_MEM_WB_TIMEOUT_EN
        else if (tmo_cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
          mem_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CntW'(1);
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    // INPUT data is sampled at the end of the strobe cycle and written back the next cycle.
    if (io_rd_strb_q) begin
      wb_en_d   = 1'b1;
      wb_addr_d = in_dest_q;
      wb_data_d = {{(DW-8){1'b0}}, io_in_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      io_port_id_q  <= '0;
      io_rd_strb_q  <= 1'b0;
      io_wr_strb_q  <= 1'b0;
      io_out_data_q <= '0;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      carry_q       <= 1'b0;
      ld_dest_q     <= '0;
      in_dest_q     <= '0;
`ifdef PL_MEM_WB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      mem_err_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      io_port_id_q  <= io_port_id_d;
      io_rd_strb_q  <= io_rd_strb_d;
      io_wr_strb_q  <= io_wr_strb_d;
      io_out_data_q <= io_out_data_d;
      wb_en_q       <= wb_en_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      carry_q       <= carry_d;
      ld_dest_q     <= ld_dest_d;
      in_dest_q     <= in_dest_d;
`ifdef PL_MEM_WB_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      mem_err_q     <= mem_err_d;
`endif
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign io_port_id   = io_port_id_q;
  assign io_rd_strobe = io_rd_strb_q;
  assign io_wr_strobe = io_wr_strb_q;
  assign io_out_data  = io_out_data_q;
  assign wb_en        = wb_en_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign carry_flag   = carry_q;
  assign stall        = (state_q == StMemWait);
`ifdef PL_MEM_WB_TIMEOUT_EN
  assign mem_err      = mem_err_q;
`else
  assign mem_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pl_mem_wb.sv
// Self-checking bench for pl_mem_wb: randomized instructions against a behavioural stage model.
module tb_pl_mem_wb;
  localparam int unsigned ND = 2;
  localparam int unsigned DW = ND * 8;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [0:9]    EX_reg;
  logic [3:0]    destination_reg_addr;
  logic [DW-1:0] operation_result;
  logic [15:0]   data_wr_addr, data_rd_addr;
  logic [7:0]    IO_port_ID;
  logic [0:4]    branch_conds_EX;
  logic          mem_req, mem_we;
  logic [15:0]   mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          mem_ack;
  logic [7:0]    io_port_id;
  logic          io_rd_strobe, io_wr_strobe;
  logic [7:0]    io_out_data, io_in_data;
  logic          wb_en;
  logic [3:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          carry_flag, stall, mem_err;

  int   n_vec = 0;
  int   n_err = 0;
  logic carry_exp = 1'b0;

  pl_mem_wb #(.NUM_DOMAINS(ND), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .EX_reg(EX_reg), .destination_reg_addr(destination_reg_addr),
    .operation_result(operation_result), .data_wr_addr(data_wr_addr),
    .data_rd_addr(data_rd_addr), .IO_port_ID(IO_port_ID), .branch_conds_EX(branch_conds_EX),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .io_port_id(io_port_id),
    .io_rd_strobe(io_rd_strobe), .io_wr_strobe(io_wr_strobe), .io_out_data(io_out_data),
    .io_in_data(io_in_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .carry_flag(carry_flag), .stall(stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_nop();
    EX_reg = '0;
    EX_reg[3] = 1'b1;
  endtask

  task automatic set_alu(input logic [DW-1:0] res, input logic [3:0] dest, input logic inv,
                         input logic sc, input logic cin);
    EX_reg = '0;
    EX_reg[1] = 1'b1;
    EX_reg[2] = sc;
    EX_reg[3] = inv;
    operation_result = res;
    destination_reg_addr = dest;
    branch_conds_EX = '0;
    branch_conds_EX[3] = cin;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_nop();
    mem_ack = 1'b0;
    mem_rdata = '0;
    io_in_data = '0;
    IO_port_ID = '0;
    data_wr_addr = '0;
    data_rd_addr = '0;
    operation_result = '0;
    destination_reg_addr = '0;
    branch_conds_EX = '0;
    carry_exp = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({mem_req, mem_we, io_rd_strobe, io_wr_strobe, wb_en, stall, carry_flag, mem_err}
        !== 8'h00) begin
      n_err++;
      $display("FAIL reset_flags: got %b, expected 00000000",
               {mem_req, mem_we, io_rd_strobe, io_wr_strobe, wb_en, stall, carry_flag, mem_err});
    end
    n_vec++;
    if ({mem_addr, mem_wdata, io_port_id, io_out_data, wb_addr, wb_data} !== '0) begin
      n_err++;
      $display("FAIL reset_buses: addr=%h wdata=%h port=%h out=%h wba=%h wbd=%h, expected 0",
               mem_addr, mem_wdata, io_port_id, io_out_data, wb_addr, wb_data);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    set_alu(16'h1234, 4'b1011, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_nop();
    n_vec++;
    if ({wb_en, wb_addr, wb_data} !== {1'b1, 4'b1011, 16'h1234}) begin
      n_err++;
      $display("FAIL alu_wb: en=%b addr=%b data=%h, expected 1 1011 1234", wb_en, wb_addr, wb_data);
    end
    @(negedge clk);
    n_vec++;
    if (wb_en !== 1'b0) begin
      n_err++;
      $display("FAIL alu_wb_oneshot: wb_en=%b, expected 0", wb_en);
    end
  endtask

  // Each valid ALU op writes back exactly one cycle later; invalid ones leave no trace.
  task automatic test_back_to_back();
    logic          p_valid;
    logic [DW-1:0] p_res;
    logic [3:0]    p_dest;
    for (int i = 0; i <= 24; i++) begin
      if (i > 0) begin
        n_vec++;
        if (wb_en !== p_valid || (p_valid && {wb_addr, wb_data} !== {p_dest, p_res})) begin
          n_err++;
          $display("FAIL b2b_wb[%0d]: en=%b addr=%h data=%h, expected en=%b addr=%h data=%h",
                   i, wb_en, wb_addr, wb_data, p_valid, p_dest, p_res);
        end
        n_vec++;
        if (carry_flag !== carry_exp) begin
          n_err++;
          $display("FAIL b2b_carry[%0d]: got %b, expected %b", i, carry_flag, carry_exp);
        end
      end
      if (i < 24) begin
        logic inv, sc, cin;
        inv    = ($urandom_range(0, 3) == 0);
        sc     = 1'($urandom);
        cin    = 1'($urandom);
        p_res  = DW'($urandom);
        p_dest = 4'($urandom);
        p_valid = !inv;
        set_alu(p_res, p_dest, inv, sc, cin);
        if (!inv && sc) carry_exp = cin;
        @(negedge clk);
      end
    end
    set_nop();
    @(negedge clk);
  endtask

  task automatic mem_txn(input bit st, input bit both, input logic [15:0] addr,
                         input logic [7:0] data, input logic [3:0] dest, input int delay,
                         input logic [7:0] rd, input string nm);
    EX_reg = '0;
    EX_reg[0] = st;
    EX_reg[4] = !st || both;
    data_wr_addr = st ? addr : 16'($urandom);
    data_rd_addr = st ? ~addr : addr;
    operation_result = {8'($urandom), data};
    destination_reg_addr = dest;
    @(negedge clk);
    n_vec++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, st, addr} || (st && mem_wdata !== data)) begin
      n_err++;
      $display("FAIL %s_issue: req=%b we=%b addr=%h wdata=%h, expected 1 %b %h %h",
               nm, mem_req, mem_we, mem_addr, mem_wdata, st, addr, data);
    end
    // A valid-looking ALU op with carry save, frozen in EX during the wait, must be ignored.
    set_alu(DW'($urandom), 4'($urandom), 1'b0, 1'b1, ~carry_exp);
    for (int k = 1; k <= delay; k++) begin
      n_vec++;
      if ({stall, mem_req, wb_en, mem_err} !== 4'b1100) begin
        n_err++;
        $display("FAIL %s_wait[%0d]: stall=%b req=%b wb_en=%b err=%b, expected 1 1 0 0",
                 nm, k, stall, mem_req, wb_en, mem_err);
      end
      if (k == delay) begin
        mem_ack = 1'b1;
        mem_rdata = rd;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
    end
    set_nop();
    n_vec++;
    if ({stall, mem_req} !== 2'b00 ||
        (!st && {wb_en, wb_addr, wb_data} !== {1'b1, dest, 8'h00, rd}) ||
        (st && wb_en !== 1'b0)) begin
      n_err++;
      $display("FAIL %s_done: stall=%b req=%b en=%b addr=%h data=%h, expected 0 0 %b %h %h",
               nm, stall, mem_req, wb_en, wb_addr, wb_data, !st, dest, {8'h00, rd});
    end
    @(negedge clk);
    n_vec++;
    if ({wb_en, stall, carry_flag} !== {2'b00, carry_exp}) begin
      n_err++;
      $display("FAIL %s_after: wb_en=%b stall=%b carry=%b, expected 0 0 %b",
               nm, wb_en, stall, carry_flag, carry_exp);
    end
  endtask

  task automatic test_load();
    mem_txn(1'b0, 1'b0, 16'h00A5, 8'h00, 4'b0011, 3, 8'h7C, "load_a5");
  endtask

  task automatic test_store();
    mem_txn(1'b1, 1'b0, 16'h0102, 8'h55, 4'b0001, 1, 8'hEE, "store_0102");
    mem_txn(1'b1, 1'b1, 16'h3C3C, 8'hA7, 4'b0110, 2, 8'h11, "store_wins");
  endtask

  task automatic test_invalid_load();
    EX_reg = '0;
    EX_reg[4] = 1'b1;
    EX_reg[3] = 1'b1;
    data_rd_addr = 16'h4242;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if ({mem_req, stall} !== 2'b00) begin
        n_err++;
        $display("FAIL invalid_load[%0d]: req=%b stall=%b, expected 0 0", i, mem_req, stall);
      end
    end
    set_nop();
  endtask

  task automatic test_io();
    logic [7:0] port, od, id;
    logic [3:0] dest;
    port = 8'($urandom);
    od = 8'($urandom);
    EX_reg = '0;
    EX_reg[8] = 1'b1;
    IO_port_ID = port;
    operation_result = {8'hFF, od};
    @(negedge clk);
    set_nop();
    n_vec++;
    if ({io_wr_strobe, io_rd_strobe, wb_en, io_port_id, io_out_data} !== {3'b100, port, od}) begin
      n_err++;
      $display("FAIL output_strobe: wr=%b rd=%b wb=%b port=%h data=%h, expected 1 0 0 %h %h",
               io_wr_strobe, io_rd_strobe, wb_en, io_port_id, io_out_data, port, od);
    end
    @(negedge clk);
    n_vec++;
    if ({io_wr_strobe, wb_en} !== 2'b00) begin
      n_err++;
      $display("FAIL output_oneshot: wr=%b wb=%b, expected 0 0", io_wr_strobe, wb_en);
    end
    port = 8'($urandom);
    id = 8'($urandom);
    dest = 4'($urandom);
    EX_reg = '0;
    EX_reg[9] = 1'b1;
    EX_reg[1] = 1'b1;
    IO_port_ID = port;
    destination_reg_addr = dest;
    @(negedge clk);
    set_nop();
    n_vec++;
    if ({io_rd_strobe, io_wr_strobe, wb_en, io_port_id} !== {3'b100, port}) begin
      n_err++;
      $display("FAIL input_strobe: rd=%b wr=%b wb=%b port=%h, expected 1 0 0 %h",
               io_rd_strobe, io_wr_strobe, wb_en, io_port_id, port);
    end
    io_in_data = id;
    @(negedge clk);
    io_in_data = ~id;
    n_vec++;
    if ({io_rd_strobe, wb_en, wb_addr, wb_data} !== {2'b01, dest, 8'h00, id}) begin
      n_err++;
      $display("FAIL input_wb: rd=%b en=%b addr=%h data=%h, expected 0 1 %h %h",
               io_rd_strobe, wb_en, wb_addr, wb_data, dest, {8'h00, id});
    end
    @(negedge clk);
    n_vec++;
    if (wb_en !== 1'b0) begin
      n_err++;
      $display("FAIL input_wb_oneshot: wb_en=%b, expected 0", wb_en);
    end
  endtask

  task automatic test_ack_outside();
    mem_ack = 1'b1;
    mem_rdata = 8'h99;
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++;
    if ({mem_req, stall, wb_en} !== 3'b000) begin
      n_err++;
      $display("FAIL stray_ack: req=%b stall=%b wb_en=%b, expected 0 0 0", mem_req, stall, wb_en);
    end
  endtask

  task automatic test_random_mem();
    for (int i = 0; i < 8; i++) begin
      mem_txn(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 4'($urandom),
              int'($urandom_range(1, 4)), 8'($urandom), "rand_mem");
    end
  endtask

  task automatic test_no_ack();
`ifdef PL_MEM_WB_TIMEOUT_EN
    EX_reg = '0;
    EX_reg[4] = 1'b1;
    data_rd_addr = 16'hBEEF;
    @(negedge clk);
    set_nop();
    for (int k = 1; k <= TMO; k++) begin
      n_vec++;
      if ({stall, mem_req} !== 2'b11) begin
        n_err++;
        $display("FAIL tmo_wait[%0d]: stall=%b req=%b, expected 1 1", k, stall, mem_req);
      end
      @(negedge clk);
    end
    n_vec++;
    if ({stall, mem_req, wb_en, mem_err} !== 4'b0001) begin
      n_err++;
      $display("FAIL tmo_abort: stall=%b req=%b wb=%b err=%b, expected 0 0 0 1",
               stall, mem_req, wb_en, mem_err);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({wb_en, mem_err} !== 2'b01) begin
      n_err++;
      $display("FAIL tmo_sticky: wb=%b err=%b, expected 0 1", wb_en, mem_err);
    end
`else
    mem_txn(1'b0, 1'b0, 16'hBEEF, 8'h00, 4'b1110, 20, 8'hC3, "long_wait");
`endif
  endtask

  task automatic test_reset_mid();
    EX_reg = '0;
    EX_reg[4] = 1'b1;
    data_rd_addr = 16'h0F0F;
    destination_reg_addr = 4'b0101;
    @(negedge clk);
    set_nop();
    @(negedge clk);
    n_vec++;
    if (mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_pre: req=%b, expected 1", mem_req);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, stall, mem_err, carry_flag} !== 4'b0000) begin
      n_err++;
      $display("FAIL rstmid_async: req=%b stall=%b err=%b carry=%b, expected 0 0 0 0",
               mem_req, stall, mem_err, carry_flag);
    end
    carry_exp = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 8'h5A;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({wb_en, mem_req, stall} !== 3'b000) begin
        n_err++;
        $display("FAIL rstmid_post[%0d]: wb=%b req=%b stall=%b, expected 0 0 0",
                 i, wb_en, mem_req, stall);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_store();
    test_invalid_load();
    test_io();
    test_ack_outside();
    test_random_mem();
    test_no_ack();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
